// File: rtl/regfile_sb.sv
// Multi-port integer register file with per-register busy scoreboard.
// Combinational reads with write bypass; x0 hardwired to zero.
module regfile_sb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                wr_clr,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [NREGS-1:0]    busy_vec,
    output logic                any_busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int r = 1; r < NREGS; r++) begin
            busy_next[r] = (busy[r] & ~(wr_en & wr_clr & (wr_addr == AW'(r))))
                         | (sb_set & (sb_addr == AW'(r)));
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_en && wr_addr != '0) begin
                regs[wr_addr] <= wr_data;
            end
            busy <= busy_next;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        logic          set_hit;

        assign a       = rd_addr[i*AW +: AW];
        assign hit     = wr_en && (wr_addr == a) && (a != '0);
        assign set_hit = sb_set && (sb_addr == a);

        assign rd_data[i*XLEN +: XLEN] = (a == '0) ? '0 :
                                         hit ? wr_data : regs[a];
        // a retiring write hides the busy bit unless a new producer claims it
        assign rd_busy[i] = busy[a] & ~(hit & wr_clr & ~set_hit);
    end

    assign busy_vec = busy;
    assign any_busy = |busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default config plus a 4-port 32-bit
// 16-register instance.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // instance a: XLEN=64, NREGS=32, NRD=2
    logic         rst;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic         wr_en, wr_clr, sb_set;
    logic [4:0]   wr_addr, sb_addr;
    logic [63:0]  wr_data;
    logic [31:0]  busy_vec;
    logic         any_busy;

    regfile_sb dut_a (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_clr(wr_clr), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy_vec(busy_vec), .any_busy(any_busy)
    );

    // instance b: XLEN=32, NREGS=16, NRD=4
    logic         rst_b;
    logic [15:0]  rd_addr_b;
    logic [127:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic         wr_en_b, wr_clr_b, sb_set_b;
    logic [3:0]   wr_addr_b, sb_addr_b;
    logic [31:0]  wr_data_b;
    logic [15:0]  busy_vec_b;
    logic         any_busy_b;

    regfile_sb #(.XLEN(32), .NREGS(16), .NRD(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .wr_clr(wr_clr_b), .sb_set(sb_set_b), .sb_addr(sb_addr_b),
        .busy_vec(busy_vec_b), .any_busy(any_busy_b)
    );

    task automatic idle_a();
        wr_en = 0; wr_clr = 0; sb_set = 0;
        wr_addr = 0; sb_addr = 0; wr_data = 0;
    endtask

    task automatic idle_b();
        wr_en_b = 0; wr_clr_b = 0; sb_set_b = 0;
        wr_addr_b = 0; sb_addr_b = 0; wr_data_b = 0;
    endtask

    initial begin
        rst = 1; rst_b = 1;
        rd_addr = 0; rd_addr_b = 0;
        idle_a(); idle_b();
        step();
        rst = 0; rst_b = 0;

        // reset state
        for (int r = 1; r < 32; r++) begin
            rd_addr = {r[4:0], r[4:0]};
            #1;
            check($sformatf("rst_rd0_x%0d", r), rd_data[63:0], 64'd0);
            check($sformatf("rst_rd1_x%0d", r), rd_data[127:64], 64'd0);
        end
        check("rst_busy_vec", {32'd0, busy_vec}, 64'd0);
        check("rst_any_busy", {63'd0, any_busy}, 64'd0);

        // write with same-cycle bypass
        wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF_0000_0001;
        rd_addr = {5'd0, 5'd5};
        #1;
        check("byp_rd0", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
        check("byp_rd1_x0", rd_data[127:64], 64'd0);
        step();
        idle_a();
        #1;
        check("wr_stored", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);

        // x0 is immune to writes and scoreboard
        wr_en = 1; wr_addr = 0; wr_data = '1;
        sb_set = 1; sb_addr = 0; wr_clr = 0;
        rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_byp", rd_data[63:0], 64'd0);
        step();
        idle_a();
        #1;
        check("x0_rd", rd_data[63:0], 64'd0);
        check("x0_rd_busy", {62'd0, rd_busy}, 64'd0);
        check("x0_busy_vec", {32'd0, busy_vec}, 64'd0);

        // scoreboard lifecycle on x7
        sb_set = 1; sb_addr = 7; rd_addr = {5'd0, 5'd7};
        #1;
        check("sb_not_yet", {63'd0, rd_busy[0]}, 64'd0);
        step();
        idle_a();
        #1;
        check("sb7_rd_busy", {63'd0, rd_busy[0]}, 64'd1);
        check("sb7_any", {63'd0, any_busy}, 64'd1);
        check("sb7_vec", {32'd0, busy_vec}, 64'h80);
        wr_en = 1; wr_clr = 1; wr_addr = 7; wr_data = 64'd42;
        #1;
        check("clr7_rd_busy", {63'd0, rd_busy[0]}, 64'd0);
        check("clr7_rd", rd_data[63:0], 64'd42);
        check("clr7_vec_reg", {32'd0, busy_vec}, 64'h80);
        step();
        idle_a();
        #1;
        check("clr7_vec", {32'd0, busy_vec}, 64'd0);
        check("clr7_stored", rd_data[63:0], 64'd42);

        // set and clear collide on x9
        sb_set = 1; sb_addr = 9;
        step();
        idle_a();
        wr_en = 1; wr_clr = 1; wr_addr = 9; wr_data = 64'h99;
        sb_set = 1; sb_addr = 9; rd_addr = {5'd0, 5'd9};
        #1;
        check("col_rd_busy", {63'd0, rd_busy[0]}, 64'd1);
        step();
        idle_a();
        #1;
        check("col_vec", {32'd0, busy_vec}, 64'h200);
        check("col_data", rd_data[63:0], 64'h99);
        wr_en = 1; wr_clr = 1; wr_addr = 9; wr_data = 64'h99;
        step();
        idle_a();
        #1;
        check("col_retire", {32'd0, busy_vec}, 64'd0);

        // clearing write to an idle register is harmless
        wr_en = 1; wr_clr = 1; wr_addr = 11; wr_data = 64'h5;
        step();
        idle_a();
        #1;
        check("clr_idle_vec", {32'd0, busy_vec}, 64'd0);

        // reset in the middle of traffic
        sb_set = 1; sb_addr = 3;
        wr_en = 1; wr_clr = 0; wr_addr = 3; wr_data = 64'd17;
        step();
        idle_a();
        sb_set = 1; sb_addr = 4;
        step();
        idle_a();
        rd_addr = {5'd4, 5'd3};
        #1;
        check("mid_vec", {32'd0, busy_vec}, 64'h18);
        check("mid_x3", rd_data[63:0], 64'd17);
        check("mid_rd_busy", {62'd0, rd_busy}, 64'd3);
        rst = 1; wr_en = 1; wr_addr = 3; wr_data = 64'd55;
        sb_set = 1; sb_addr = 5;
        step();
        rst = 0;
        idle_a();
        #1;
        check("mrst_x3", rd_data[63:0], 64'd0);
        check("mrst_vec", {32'd0, busy_vec}, 64'd0);
        check("mrst_any", {63'd0, any_busy}, 64'd0);

        // narrow, 4-port instance
        wr_en_b = 1; wr_addr_b = 12; wr_data_b = 32'hCAFE_F00D;
        rd_addr_b = {4'd12, 4'd12, 4'd12, 4'd12};
        #1;
        for (int p = 0; p < 4; p++)
            check($sformatf("b_byp_p%0d", p),
                  {32'd0, rd_data_b[p*32 +: 32]}, 64'hCAFE_F00D);
        step();
        idle_b();
        #1;
        for (int p = 0; p < 4; p++)
            check($sformatf("b_rd_p%0d", p),
                  {32'd0, rd_data_b[p*32 +: 32]}, 64'hCAFE_F00D);
        sb_set_b = 1; sb_addr_b = 15;
        rd_addr_b = {4'd0, 4'd15, 4'd12, 4'd15};
        step();
        idle_b();
        #1;
        check("b_rd_busy", {60'd0, rd_busy_b}, 64'h5);
        check("b_vec", {48'd0, busy_vec_b}, 64'h8000);
        check("b_x0", {32'd0, rd_data_b[127:96]}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
